mem_port_arbiter: RTL and testbench

Single-port RAM arbiter and scheduler for the KANADE32 pipeline. It shares the one synchronous RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Each cycle it grants at most one requester, drives the RAM address and write controls, and routes the one-cycle-latency read data back to the owner. The pipeline controller uses the grant signals to stall PC/stage-register writes.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous single-port RAM between instruction fetch and data access.
// Optional fetch starvation guard is compiled in when MEM_PORT_ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [29:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_q,
   output logic [1:0]  dbg_owner_o
);

   // Handshake: a requester holds req/addr stable until it sees gnt in the same cycle;
   // read data returns one cycle after the grant, writes complete in the grant cycle.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_IF    = 2'd1,
      OWN_D_RD  = 2'd2,
      OWN_D_ERR = 2'd3
   } owner_e;

   owner_e owner_q, owner_d;
   logic   if_win;
   logic   d_win;
   logic   d_misaligned;
   logic   force_if;

   assign d_misaligned = (d_addr[1:0] != 2'b00);

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q, starve_d;

   assign force_if = (starve_q == LIMIT);

   // Counts consecutive denied fetch cycles; any fetch grant or idle fetch clears it.
   always_comb begin
      starve_d = 4'd0;
      if (if_req && !if_win) begin
         starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^if_addr[1:0];
`else
   assign force_if = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{if_addr[1:0], 4'(STARVE_LIMIT)};
`endif

   assign if_win = !reset && if_req && (!d_req || force_if);
   assign d_win  = !reset && d_req && !(if_req && force_if);

   assign if_gnt = if_win;
   assign d_gnt  = d_win;

   always_comb begin
      ram_addr  = 30'd0;
      ram_we    = 1'b0;
      ram_wdata = 32'd0;
      if (if_win) begin
         ram_addr = if_addr[31:2];
      end else if (d_win) begin
         ram_addr  = d_addr[31:2];
         ram_we    = d_we && !d_misaligned;
         ram_wdata = d_wdata;
      end
   end

   // Owner records who the next cycle's ram_q belongs to; aligned writes expect no response.
   always_comb begin
      owner_d = OWN_NONE;
      if (if_win) begin
         owner_d = OWN_IF;
      end else if (d_win) begin
         if (d_misaligned) begin
            owner_d = OWN_D_ERR;
         end else if (!d_we) begin
            owner_d = OWN_D_RD;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign if_rvalid   = (owner_q == OWN_IF);
   assign d_rvalid    = (owner_q == OWN_D_RD) || (owner_q == OWN_D_ERR);
   assign d_err       = (owner_q == OWN_D_ERR);
   assign if_rdata    = if_rvalid ? ram_q : 32'd0;
   assign d_rdata     = (owner_q == OWN_D_RD) ? ram_q : 32'd0;
   assign dbg_owner_o = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal cases plus random traffic against a queue-based model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_IF   = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [29:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  logic [1:0]  dbg_owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .dbg_owner_o(dbg_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'h1234_5678 ^ (32'(i) * 32'h0101_0107);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment (64 words) ----------------
  logic [31:0] ram_mem [0:63];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
      ram_q <= 32'd0;
    end else begin
      if (ram_we) ram_mem[ram_addr[5:0]] <= ram_wdata;
      ram_q <= ram_mem[ram_addr[5:0]];
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [31:0] shadow [0:63];
  int          denied;
  logic        m_if_gnt, m_d_gnt;
  logic        forced;
  logic [33:0] e;
  logic [29:0] m_addr;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      denied = 0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      m_if_gnt = 1'b0;
      m_d_gnt  = 1'b0;
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      check("rst_rvalid", {29'd0, if_rvalid, d_rvalid, d_err}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : {K_NONE, 32'd0};
      check("if_rvalid", 32'(if_rvalid), 32'(e[33:32] == K_IF));
      check("d_rvalid", 32'(d_rvalid), 32'(e[33:32] == K_RD || e[33:32] == K_ERR));
      check("d_err", 32'(d_err), 32'(e[33:32] == K_ERR));
      check("if_rdata", if_rdata, (e[33:32] == K_IF) ? e[31:0] : 32'd0);
      check("d_rdata", d_rdata, (e[33:32] == K_RD) ? e[31:0] : 32'd0);

      forced   = GUARD && (denied >= LIMIT);
      m_if_gnt = if_req && (!d_req || forced);
      m_d_gnt  = d_req && !(if_req && forced);
      m_addr   = m_if_gnt ? if_addr[31:2] : (m_d_gnt ? d_addr[31:2] : 30'd0);
      check("if_gnt", 32'(if_gnt), 32'(m_if_gnt));
      check("d_gnt", 32'(d_gnt), 32'(m_d_gnt));
      check("ram_addr", 32'(ram_addr), 32'(m_addr));
      check("ram_we", 32'(ram_we), 32'(m_d_gnt && d_we && d_addr[1:0] == 2'b00));
      check("ram_wdata", ram_wdata, m_d_gnt ? d_wdata : 32'd0);

      if (m_if_gnt) exp_q.push_back({K_IF, shadow[if_addr[7:2]]});
      else if (m_d_gnt && d_addr[1:0] != 2'b00) exp_q.push_back({K_ERR, 32'd0});
      else if (m_d_gnt && !d_we) exp_q.push_back({K_RD, shadow[d_addr[7:2]]});
      else begin
        if (m_d_gnt) shadow[d_addr[7:2]] = d_wdata;
        exp_q.push_back({K_NONE, 32'd0});
      end

      denied = (if_req && !m_if_gnt) ? denied + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd);
    next_cycle();
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  logic [9:0] if_seq;
  logic [9:0] exp_seq;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // fetch only
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_fetch_gnt", 32'(if_gnt), 32'd1);
    check("lit_fetch_addr", 32'(ram_addr), 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_fetch_rvalid", 32'(if_rvalid), 32'd1);
    check("lit_fetch_rdata", if_rdata, init_word(4));

    // contention, data read wins
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("lit_cont_dgnt", {30'd0, if_gnt, d_gnt}, 32'b01);
    check("lit_cont_addr", 32'(ram_addr), 32'h8);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_cont_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'b01);
    check("lit_cont_rdata", d_rdata, init_word(8));

    // aligned write
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    check("lit_wr_we", 32'(ram_we), 32'd1);
    check("lit_wr_addr", 32'(ram_addr), 32'h10);
    check("lit_wr_data", ram_wdata, 32'hDEADBEEF);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_wr_norsp", 32'(d_rvalid), 32'd0);

    // misaligned write
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'h5555AAAA);
    @(negedge clk);
    check("lit_mis_gnt_we", {30'd0, d_gnt, ram_we}, 32'b10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_mis_err", {30'd0, d_rvalid, d_err}, 32'b11);

    // starvation: both held for 10 cycles
    exp_seq = GUARD ? 10'b10_0001_0000 : 10'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      if_seq[i] = if_gnt;
    end
    check("lit_starve_seq", 32'(if_seq), 32'(exp_seq));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset mid-read
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_rst_pre_gnt", 32'(if_gnt), 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("lit_rst_outputs", {28'd0, if_gnt, if_rvalid, d_rvalid, d_err}, 32'd0);
    next_cycle();
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("lit_rst_post_rvalid", 32'(if_rvalid), 32'd0);
    check("lit_rst_post_owner", 32'(dbg_owner), 32'd0);

    // random traffic, with a reset pulse midway
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (c == 1500) reset = 1'b1;
      if (c == 1502) reset = 1'b0;
      if (!if_req || m_if_gnt) begin
        if ($urandom_range(0, 3) != 0) begin
          if_req  = 1'b1;
          if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        end else begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req || m_d_gnt) begin
        if ($urandom_range(0, 3) != 0) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = {24'd0, 6'($urandom_range(0, 63)),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
